// File: rtl/switch_poll_pkg.sv
// Shared constants and types for the switch poll controller.
// CSR addresses, CTRL bit positions and the poll FSM state encoding.
package switch_poll_pkg;

  localparam logic [1:0] ADDR_STABLE = 2'd0;
  localparam logic [1:0] ADDR_EDGE   = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int CTRL_MASK_LSB = 0;
  localparam int CTRL_MASK_MSB = 1;
  localparam int CTRL_ENABLE   = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE
  } poll_state_t;

endpackage

// File: rtl/switch_debounce_filter.sv
// Debounce filter: stable follows sample after DEBOUNCE_COUNT matching polls.
// Ports: clk, reset, sample_valid, sample in; stable, rise_pulse, fall_pulse out.
module switch_debounce_filter #(
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic sample,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [7:0] DC = 8'(DEBOUNCE_COUNT);

  logic       candidate;
  logic [7:0] match_cnt;
  logic       cand_nxt;
  logic [7:0] cnt_nxt;
  logic       update;

  always_comb begin
    cand_nxt = candidate;
    cnt_nxt  = match_cnt;
    if (sample != candidate) begin
      cand_nxt = sample;
      cnt_nxt  = 8'd1;
    end else if (match_cnt < DC) begin
      cnt_nxt = match_cnt + 8'd1;
    end
  end

  // Judged on the post-update candidate/count so DC=1 follows in one poll.
  assign update = sample_valid && (cnt_nxt == DC)
               && (cand_nxt != stable);
  assign rise_pulse = update && cand_nxt;
  assign fall_pulse = update && !cand_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      candidate <= 1'b0;
      match_cnt <= 8'd0;
      stable    <= 1'b0;
    end else if (sample_valid) begin
      candidate <= cand_nxt;
      match_cnt <= cnt_nxt;
      if (update) stable <= cand_nxt;
    end
  end

endmodule

// File: rtl/switch_poll_ctrl.sv
// Polls a switch PIO, debounces it, captures edges and raises an irq.
// Ports: clk, reset, m_* (PIO master), s_* (CSR slave), irq.
module switch_poll_ctrl #(
  parameter int POLL_PERIOD    = 1000,
  parameter int DEBOUNCE_COUNT = 4,
  parameter int PERIOD_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  m_address,
  output logic        m_read,
  input  logic [31:0] m_readdata,
  input  logic [1:0]  s_address,
  input  logic        s_read,
  input  logic        s_write,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic        irq
);

  import switch_poll_pkg::*;

  poll_state_t         state;
  poll_state_t         state_nxt;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] period_cnt_nxt;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] reload_val;
  logic [1:0]          edge_cap;
  logic [1:0]          irq_mask;
  logic                enable;
  logic                sample_valid;
  logic                stable;
  logic                rise;
  logic                fall;
  logic                wr_edge;
  logic                wr_ctrl;
  logic                wr_period;
  logic [1:0]          clr_mask;
  logic [31:0]         rd_mux;
  logic                unused_bits;

  assign unused_bits = ^{m_readdata[31:1], s_writedata};

  // A zero period behaves as a period of one.
  assign reload_val = (period == '0) ? '0 : period - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      period_cnt <= '0;
    end else begin
      state      <= state_nxt;
      period_cnt <= period_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = period_cnt;
    unique case (state)
      IDLE: begin
        if (enable && period_cnt == '0)
          state_nxt = READ;
        else if (period_cnt != '0)
          period_cnt_nxt = period_cnt - 1'b1;
      end
      READ: state_nxt = CAPTURE;
      CAPTURE: begin
        state_nxt      = IDLE;
        period_cnt_nxt = reload_val;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_address    = 2'd0;
    m_read       = (state == READ);
    sample_valid = (state == CAPTURE);
  end

  switch_debounce_filter #(
    .DEBOUNCE_COUNT(DEBOUNCE_COUNT)
  ) u_filter (
    .clk         (clk),
    .reset       (reset),
    .sample_valid(sample_valid),
    .sample      (m_readdata[0]),
    .stable      (stable),
    .rise_pulse  (rise),
    .fall_pulse  (fall)
  );

  assign wr_edge   = s_write && (s_address == ADDR_EDGE);
  assign wr_ctrl   = s_write && (s_address == ADDR_CTRL);
  assign wr_period = s_write && (s_address == ADDR_PERIOD);
  assign clr_mask  = wr_edge ? s_writedata[1:0] : 2'b00;

  always_comb begin
    rd_mux = 32'd0;
    unique case (1'b1)
      (s_address == ADDR_STABLE): rd_mux[0] = stable;
      (s_address == ADDR_EDGE):   rd_mux[1:0] = edge_cap;
      (s_address == ADDR_CTRL): begin
        rd_mux[CTRL_MASK_MSB:CTRL_MASK_LSB] = irq_mask;
        rd_mux[CTRL_ENABLE] = enable;
      end
      (s_address == ADDR_PERIOD): rd_mux = 32'(period);
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_cap   <= 2'b00;
      irq_mask   <= 2'b00;
      enable     <= 1'b1;
      period     <= PERIOD_W'(POLL_PERIOD);
      s_readdata <= 32'd0;
      irq        <= 1'b0;
    end else begin
      // New edges override a same-cycle W1C clear.
      edge_cap <= (edge_cap & ~clr_mask) | {fall, rise};
      if (wr_ctrl) begin
        irq_mask <= s_writedata[CTRL_MASK_MSB:CTRL_MASK_LSB];
        enable   <= s_writedata[CTRL_ENABLE];
      end
      if (wr_period) period <= s_writedata[PERIOD_W-1:0];
      if (s_read) s_readdata <= rd_mux;
      irq <= |(edge_cap & irq_mask);
    end
  end

endmodule

// File: tb/tb_switch_poll_ctrl.sv
// Self-checking bench for switch_poll_ctrl.
// CSR reads go through an expected-value queue popped on readdata.
module tb_switch_poll_ctrl;

  localparam int PP = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  m_address;
  logic        m_read;
  logic [31:0] m_readdata = 32'd0;
  logic [1:0]  s_address;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        irq;
  logic        sw;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  // PIO model: registered readdata, one cycle of latency.
  always @(posedge clk) m_readdata <= {31'd0, sw};

  switch_poll_ctrl #(
    .POLL_PERIOD(PP),
    .DEBOUNCE_COUNT(3),
    .PERIOD_W(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .m_address  (m_address),
    .m_read     (m_read),
    .m_readdata (m_readdata),
    .s_address  (s_address),
    .s_read     (s_read),
    .s_write    (s_write),
    .s_writedata(s_writedata),
    .s_readdata (s_readdata),
    .irq        (irq)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic csr_write(input logic [1:0] a,
                           input logic [31:0] d);
    s_address   = a;
    s_writedata = d;
    s_write     = 1'b1;
    tick();
    s_write     = 1'b0;
  endtask

  task automatic csr_read(input logic [1:0] a,
                          input logic [31:0] e,
                          input string n);
    logic [31:0] want;
    string       nm;
    s_address = a;
    s_read    = 1'b1;
    exp_q.push_back(e);
    name_q.push_back(n);
    tick();
    s_read = 1'b0;
    want = exp_q.pop_front();
    nm   = name_q.pop_front();
    checks++;
    if (s_readdata !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, s_readdata, want);
    end
  endtask

  task automatic wait_mread(output int n, input string nm);
    bit bad_addr;
    bad_addr = 0;
    n = 0;
    do begin
      tick();
      n++;
      if (m_address !== 2'd0) bad_addr = 1;
    end while (m_read !== 1'b1 && n < 2000);
    checks++;
    if (m_read !== 1'b1 || bad_addr) begin
      errors++;
      $display("FAIL %s: m_read %b addr_bad %0d want poll",
               nm, m_read, bad_addr);
    end
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    sw = 1'b0;
    s_address = 2'd0;
    s_read = 1'b0;
    s_write = 1'b0;
    s_writedata = 32'd0;
    tick();
    tick();
    checks++;
    if ({m_read, irq, m_address} !== 4'b0 || s_readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_out: mr %b irq %b ma %h rd %h want 0",
               m_read, irq, m_address, s_readdata);
    end
    reset = 1'b0;
    wait_mread(n, "first_poll");
    wait_mread(n, "poll_a");
    checks++;
    if (n !== PP + 2) begin
      errors++;
      $display("FAIL cadence_a: got %0d want %0d", n, PP + 2);
    end
    wait_mread(n, "poll_b");
    checks++;
    if (n !== PP + 2) begin
      errors++;
      $display("FAIL cadence_b: got %0d want %0d", n, PP + 2);
    end
    csr_read(2'd0, 32'h0, "rst_csr0");
    csr_read(2'd1, 32'h0, "rst_csr1");
    csr_read(2'd2, 32'h100, "rst_csr2");
    csr_read(2'd3, 32'(PP), "rst_csr3");
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL rst_irq: got %b want 0", irq);
    end
  endtask

  task automatic test_glitch;
    int n;
    csr_write(2'd3, 32'd4);
    sw = 1'b1;
    wait_mread(n, "gl_p1");
    wait_mread(n, "gl_p2");
    tick();
    sw = 1'b0;
    wait_mread(n, "gl_p3");
    wait_mread(n, "gl_p4");
    wait_mread(n, "gl_p5");
    tick();
    tick();
    csr_read(2'd0, 32'h0, "gl_stable");
    csr_read(2'd1, 32'h0, "gl_edge");
  endtask

  task automatic test_rise;
    int n;
    csr_write(2'd2, 32'h101);
    sw = 1'b1;
    wait_mread(n, "ri_p1");
    wait_mread(n, "ri_p2");
    tick();
    tick();
    csr_read(2'd0, 32'h0, "ri_stable2");
    wait_mread(n, "ri_p3");
    tick();
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL ri_irq_lag: got %b want 0", irq);
    end
    csr_read(2'd0, 32'h1, "ri_stable3");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL ri_irq: got %b want 1", irq);
    end
    csr_read(2'd1, 32'h1, "ri_edge");
  endtask

  task automatic test_w1c_fall;
    int n;
    csr_write(2'd2, 32'h103);
    sw = 1'b0;
    wait_mread(n, "fa_p1");
    wait_mread(n, "fa_p2");
    wait_mread(n, "fa_p3");
    tick();
    csr_write(2'd1, 32'h3);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL fa_irq_hold: got %b want 1", irq);
    end
    csr_read(2'd1, 32'h2, "fa_setwins");
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL fa_irq_fall: got %b want 1", irq);
    end
    csr_write(2'd1, 32'h2);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL fa_irq_lag: got %b want 1", irq);
    end
    tick();
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL fa_irq_clr: got %b want 0", irq);
    end
    csr_read(2'd1, 32'h0, "fa_edge_clr");
    csr_read(2'd0, 32'h0, "fa_stable");
  endtask

  task automatic test_enable;
    int n;
    int polls;
    sw = 1'b1;
    wait_mread(n, "en_p1");
    wait_mread(n, "en_p2");
    csr_write(2'd2, 32'h003);
    polls = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_read === 1'b1) polls++;
    end
    checks++;
    if (polls !== 0) begin
      errors++;
      $display("FAIL en_hold: got %0d polls want 0", polls);
    end
    csr_read(2'd0, 32'h0, "en_stable_hold");
    csr_write(2'd2, 32'h103);
    wait_mread(n, "en_p3");
    tick();
    tick();
    csr_read(2'd0, 32'h1, "en_resume");
    csr_read(2'd2, 32'h103, "en_ctrl");
  endtask

  task automatic test_period0_reset;
    int n;
    csr_write(2'd3, 32'd0);
    wait_mread(n, "p0_a");
    wait_mread(n, "p0_b");
    wait_mread(n, "p0_c");
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL p0_cad1: got %0d want 3", n);
    end
    wait_mread(n, "p0_d");
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL p0_cad2: got %0d want 3", n);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (m_read !== 1'b0 || irq !== 1'b0 || s_readdata !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: mr %b irq %b rd %h want 0 0 0",
               m_read, irq, s_readdata);
    end
    csr_read(2'd0, 32'h0, "mr_csr0");
    csr_read(2'd1, 32'h0, "mr_csr1");
    csr_read(2'd2, 32'h100, "mr_csr2");
    csr_read(2'd3, 32'(PP), "mr_csr3");
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_w1c_fall();
    test_enable();
    test_period0_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_poll_ctrl.md
Name: switch_poll_ctrl

Overview:
- Avalon-MM master/slave controller that sequences reads of the single-bit switch PIO input slave (address 0, registered readdata, fixed 1-cycle read latency, no waitrequest).
- Polls the PIO at a programmable interval, debounces the sampled bit, captures rising/falling edges and raises a maskable interrupt.
- Sits between the switch PIO and the Nios II data master and offloads polling from software.

Parameters:
- POLL_PERIOD, 1000: reset value of the poll interval register, in clk cycles.
- DEBOUNCE_COUNT, 4: consecutive identical samples required before the stable value updates; legal range 1..255.
- PERIOD_W, 16: width of the poll interval register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- m_address  out  2  PIO address; always 0
- m_read  out  1  PIO read strobe
- m_readdata  in  32  PIO read data; only bit 0 is used
- s_address  in  2  CSR address
- s_read  in  1  CSR read strobe
- s_write  in  1  CSR write strobe
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, registered, 1-cycle latency
- irq  out  1  level interrupt

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on reset.
- Reset values:
  - m_read=0, m_address=0, s_readdata=0, irq=0
  - state=IDLE, period_cnt=0, stable=0, candidate=0, match_cnt=0
  - edge_cap=0, irq_mask=0, enable=1, period=POLL_PERIOD
- FSM states: IDLE, READ, CAPTURE.
  - IDLE: if enable and period_cnt==0, go to READ; otherwise decrement period_cnt (hold at 0 when disabled).
  - READ: m_read=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: sample m_readdata[0], reload period_cnt=max(period,1)-1, go to IDLE.
  - Poll cadence is therefore max(period,1)+2 cycles.
- Debounce, evaluated in the CAPTURE cycle with sample s:
  - s!=candidate: candidate<=s, match_cnt<=1.
  - Otherwise match_cnt saturates at DEBOUNCE_COUNT.
  - When the updated match_cnt reaches DEBOUNCE_COUNT and candidate!=stable: stable<=candidate on the following cycle, and edge_cap[0] (rise) or edge_cap[1] (fall) is set.
  - DEBOUNCE_COUNT=1 means every differing sample updates stable after one poll.
- CSR map (32-bit; unused bits read 0):
  - 0 R: {31'b0, stable}
  - 1 R/W1C: edge_cap[1:0]
  - 2 R/W: [1:0] irq_mask, [8] enable
  - 3 R/W: [PERIOD_W-1:0] period
  - Writes to read-only address 0 are ignored.
- irq registered: irq <= |(edge_cap & irq_mask); asserts 1 cycle after edge_cap or irq_mask changes.
- Boundary conditions:
  - W1C clear and a new edge set in the same cycle: the set wins.
  - Period write mid-countdown: takes effect at the next reload only.
  - period=0: treated as 1.
  - Enable cleared during READ/CAPTURE: the transaction completes, then the FSM holds in IDLE; debounce state is retained.
  - Reset mid-transaction: m_read drops in the reset cycle and all state returns to reset values.
  - Simultaneous s_read and s_write to the same address: the read returns the pre-write value.

Decomposition:
- Package switch_poll_pkg:
  - CSR address constants ADDR_STABLE=0, ADDR_EDGE=1, ADDR_CTRL=2, ADDR_PERIOD=3
  - CTRL bit positions
  - FSM state enum {IDLE, READ, CAPTURE}
- Sub-module switch_debounce_filter: sample_valid/sample in; stable, rise_pulse and fall_pulse out; parameter DEBOUNCE_COUNT.

Test Plan:
- Reset, then idle with m_readdata=0: m_read pulses every POLL_PERIOD+2 cycles and m_address stays 0; CSR0=0, irq=0.
- Period=4, DEBOUNCE_COUNT=3, input switched to 1 and held: stable=1 after the third matching CAPTURE; CSR1 reads 0x1; with mask=0x1, irq=1 one cycle later.
- Glitch: input 1 for 2 polls, then 0 (DEBOUNCE_COUNT=3): stable stays 0 and CSR1 reads 0.
- Edge pending, write CSR1=0x1 in the same cycle a fall edge is set: CSR1 reads 0x2 after the write; with mask=0x3, irq stays 1; write 0x2 clears it and irq=0 next cycle.
- Write CSR2 bit8=0 during READ: one CAPTURE completes, then no further m_read; re-enable resumes polling and stable is unchanged.
- Write CSR3=0: polls occur every 3 cycles; assert reset mid-READ: m_read=0 next cycle and all CSRs read their reset values.
